// File: rtl/uart_dev.sv
// Memory-mapped UART: TX FIFO feeding an 8N1 transmitter, 8N1 receiver into a one-byte holding register.
// Optional even parity (8E1) is compiled in when UART_PARITY_EN is defined.
module uart_dev #(
   parameter int unsigned TX_FIFO_DEPTH   = 16,
   parameter logic [15:0] DEFAULT_DIVISOR = 16'd434
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  uart_addr,
   input  logic [31:0] write_data_to_uart,
   output logic [31:0] read_data_from_uart,
   input  logic        uart_write_enable,
   input  logic        uart_read_enable,
   input  logic        rxd,
   output logic        txd,
   output logic        uart_irq
);

   localparam int unsigned AW = $clog2(TX_FIFO_DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(TX_FIFO_DEPTH);

   typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PAR, ST_STOP} state_e;

   // bus decode
   logic wr_data, rd_data, rd_stat, wr_div;
   assign wr_data = uart_write_enable && (uart_addr[3:2] == 2'd0);
   assign rd_data = uart_read_enable  && (uart_addr[3:2] == 2'd0);
   assign rd_stat = uart_read_enable  && (uart_addr[3:2] == 2'd1);
   assign wr_div  = uart_write_enable && (uart_addr[3:2] == 2'd2);

   logic unused_bits;
   assign unused_bits = ^{uart_addr[1:0], write_data_to_uart[31:16]};

   logic [15:0] div_q, div_d, bit_per, half_per;
   assign bit_per  = (div_q < 16'd2) ? 16'd2 : div_q;
   assign half_per = bit_per >> 1;
   assign div_d    = wr_div ? write_data_to_uart[15:0] : div_q;

   // TX FIFO
   logic [7:0]    fifo_mem [TX_FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q;
   logic          fifo_full, fifo_empty, fifo_push, tx_pop;
   logic [7:0]    fifo_head;

   assign fifo_full  = (count_q == FULL_CNT);
   assign fifo_empty = (count_q == '0);
   assign fifo_head  = fifo_mem[rd_ptr_q];
   assign fifo_push  = wr_data && (!fifo_full || tx_pop);

   always_ff @(posedge clk) begin
      if (fifo_push) fifo_mem[wr_ptr_q] <= write_data_to_uart[7:0];
   end

   // TX FSM
   state_e      tx_st_q, tx_st_d;
   logic [15:0] tx_cnt_q, tx_cnt_d;
   logic [7:0]  tx_sh_q, tx_sh_d;
   logic [2:0]  tx_idx_q, tx_idx_d;
   logic        txd_q, txd_d;
   logic        tx_tick;
`ifdef UART_PARITY_EN
   logic        tx_par_q, tx_par_d;
`endif

   assign tx_tick = (tx_cnt_q == '0);

   always_comb begin
      tx_st_d  = tx_st_q;
      tx_cnt_d = tx_cnt_q;
      tx_sh_d  = tx_sh_q;
      tx_idx_d = tx_idx_q;
      txd_d    = txd_q;
      tx_pop   = 1'b0;
`ifdef UART_PARITY_EN
      tx_par_d = tx_par_q;
`endif
      if (tx_st_q != ST_IDLE && !tx_tick) begin
         tx_cnt_d = tx_cnt_q - 16'd1;
      end else begin
         case (tx_st_q)
            ST_START: begin
               tx_st_d  = ST_DATA;
               tx_cnt_d = bit_per - 16'd1;
               txd_d    = tx_sh_q[0];
               tx_idx_d = '0;
            end
            ST_DATA: begin
               tx_cnt_d = bit_per - 16'd1;
               if (tx_idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
                  tx_st_d = ST_PAR;
                  txd_d   = tx_par_q;
`else
                  tx_st_d = ST_STOP;
                  txd_d   = 1'b1;
`endif
               end else begin
                  tx_sh_d  = tx_sh_q >> 1;
                  txd_d    = tx_sh_q[1];
                  tx_idx_d = tx_idx_q + 3'd1;
               end
            end
`ifdef UART_PARITY_EN
            ST_PAR: begin
               tx_st_d  = ST_STOP;
               tx_cnt_d = bit_per - 16'd1;
               txd_d    = 1'b1;
            end
`endif
            default: begin
               // IDLE and end of STOP share the launch path so frames run back-to-back
               if (!fifo_empty) begin
                  tx_pop   = 1'b1;
                  tx_st_d  = ST_START;
                  tx_cnt_d = bit_per - 16'd1;
                  tx_sh_d  = fifo_head;
                  txd_d    = 1'b0;
`ifdef UART_PARITY_EN
                  tx_par_d = ^fifo_head;
`endif
               end else begin
                  tx_st_d = ST_IDLE;
                  txd_d   = 1'b1;
               end
            end
         endcase
      end
   end

   // RX path
   logic        rx_s1_q, rx_s2_q, rx_prev_q;
   state_e      rx_st_q, rx_st_d;
   logic [15:0] rx_cnt_q, rx_cnt_d;
   logic [7:0]  rx_sh_q, rx_sh_d, rx_byte_q, rx_byte_d;
   logic [2:0]  rx_idx_q, rx_idx_d;
   logic        rx_valid_q, rx_valid_d, rx_ovr_q, rx_ovr_d, tx_drop_q, tx_drop_d;
   logic        rx_done, rx_tick;
   logic        rx_perr;
`ifdef UART_PARITY_EN
   logic        rx_par_ok_q, rx_par_ok_d, rx_perr_set, rx_perr_q, rx_perr_d;
   assign rx_perr = rx_perr_q;
`else
   assign rx_perr = 1'b0;
`endif

   assign rx_tick = (rx_cnt_q == '0);

   always_comb begin
      rx_st_d  = rx_st_q;
      rx_cnt_d = rx_cnt_q;
      rx_sh_d  = rx_sh_q;
      rx_idx_d = rx_idx_q;
      rx_done  = 1'b0;
`ifdef UART_PARITY_EN
      rx_par_ok_d = rx_par_ok_q;
      rx_perr_set = 1'b0;
`endif
      if (rx_st_q != ST_IDLE && !rx_tick) begin
         rx_cnt_d = rx_cnt_q - 16'd1;
      end else begin
         case (rx_st_q)
            ST_IDLE: begin
               if (rx_prev_q && !rx_s2_q) begin
                  rx_st_d  = ST_START;
                  rx_cnt_d = half_per - 16'd1;
               end
            end
            ST_START: begin
               rx_cnt_d = bit_per - 16'd1;
               rx_idx_d = '0;
               rx_st_d  = rx_s2_q ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
               rx_cnt_d = bit_per - 16'd1;
               rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
               rx_idx_d = rx_idx_q + 3'd1;
               if (rx_idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
                  rx_st_d = ST_PAR;
`else
                  rx_st_d = ST_STOP;
`endif
               end
            end
`ifdef UART_PARITY_EN
            ST_PAR: begin
               rx_cnt_d    = bit_per - 16'd1;
               rx_par_ok_d = (rx_s2_q == ^rx_sh_q);
               rx_st_d     = ST_STOP;
            end
            default: begin
               rx_st_d = ST_IDLE;
               if (rx_s2_q) begin
                  rx_done     = rx_par_ok_q;
                  rx_perr_set = !rx_par_ok_q;
               end
            end
`else
            default: begin
               rx_st_d = ST_IDLE;
               rx_done = rx_s2_q;
            end
`endif
         endcase
      end
   end

   // a pop in the completing cycle suppresses overrun; a set beats a clear
   always_comb begin
      rx_byte_d  = rx_done ? rx_sh_q : rx_byte_q;
      rx_valid_d = rx_done ? 1'b1 : (rd_data ? 1'b0 : rx_valid_q);
      rx_ovr_d   = (rd_stat ? 1'b0 : rx_ovr_q)  | (rx_done && rx_valid_q && !rd_data);
      tx_drop_d  = (rd_stat ? 1'b0 : tx_drop_q) | (wr_data && fifo_full && !tx_pop);
`ifdef UART_PARITY_EN
      rx_perr_d  = (rd_stat ? 1'b0 : rx_perr_q) | rx_perr_set;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q      <= DEFAULT_DIVISOR;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         tx_st_q    <= ST_IDLE;
         tx_cnt_q   <= '0;
         tx_sh_q    <= '0;
         tx_idx_q   <= '0;
         txd_q      <= 1'b1;
         rx_s1_q    <= 1'b1;
         rx_s2_q    <= 1'b1;
         rx_prev_q  <= 1'b1;
         rx_st_q    <= ST_IDLE;
         rx_cnt_q   <= '0;
         rx_sh_q    <= '0;
         rx_idx_q   <= '0;
         rx_byte_q  <= '0;
         rx_valid_q <= 1'b0;
         rx_ovr_q   <= 1'b0;
         tx_drop_q  <= 1'b0;
`ifdef UART_PARITY_EN
         tx_par_q    <= 1'b0;
         rx_par_ok_q <= 1'b0;
         rx_perr_q   <= 1'b0;
`endif
      end else begin
         div_q      <= div_d;
         if (fifo_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (tx_pop)    rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q    <= count_q + {{AW{1'b0}}, fifo_push} - {{AW{1'b0}}, tx_pop};
         tx_st_q    <= tx_st_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_sh_q    <= tx_sh_d;
         tx_idx_q   <= tx_idx_d;
         txd_q      <= txd_d;
         rx_s1_q    <= rxd;
         rx_s2_q    <= rx_s1_q;
         rx_prev_q  <= rx_s2_q;
         rx_st_q    <= rx_st_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_sh_q    <= rx_sh_d;
         rx_idx_q   <= rx_idx_d;
         rx_byte_q  <= rx_byte_d;
         rx_valid_q <= rx_valid_d;
         rx_ovr_q   <= rx_ovr_d;
         tx_drop_q  <= tx_drop_d;
`ifdef UART_PARITY_EN
         tx_par_q    <= tx_par_d;
         rx_par_ok_q <= rx_par_ok_d;
         rx_perr_q   <= rx_perr_d;
`endif
      end
   end

   logic tx_busy;
   assign tx_busy  = !fifo_empty || (tx_st_q != ST_IDLE);
   assign txd      = txd_q;
   assign uart_irq = rx_valid_q | rx_ovr_q | rx_perr;

   always_comb begin
      read_data_from_uart = '0;
      case (uart_addr[3:2])
         2'd0:    read_data_from_uart = {24'b0, rx_byte_q};
         2'd1:    read_data_from_uart = {26'b0, rx_perr, tx_drop_q, rx_ovr_q, tx_busy, rx_valid_q, !fifo_full};
         2'd2:    read_data_from_uart = {16'b0, div_q};
         default: read_data_from_uart = '0;
      endcase
   end

endmodule

// File: tb/tb_uart_dev.sv
// Scoreboard bench for uart_dev: TX bytes are queued on write and checked by a line monitor,
// RX bytes are queued when driven onto rxd and checked when read back through DATA.
module tb_uart_dev;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  addr = '0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic        we = 1'b0;
   logic        re = 1'b0;
   logic        rxd = 1'b1;
   logic        txd;
   logic        irq;

   always #5 clk = ~clk;

   uart_dev #(
      .TX_FIFO_DEPTH   (16),
      .DEFAULT_DIVISOR (16'd434)
   ) dut (
      .clk                 (clk),
      .rst                 (rst),
      .uart_addr           (addr),
      .write_data_to_uart  (wdata),
      .read_data_from_uart (rdata),
      .uart_write_enable   (we),
      .uart_read_enable    (re),
      .rxd                 (rxd),
      .txd                 (txd),
      .uart_irq            (irq)
   );

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   logic [7:0]  tx_exp [$];
   logic [7:0]  rx_exp [$];
   int unsigned tb_div = 434;
   bit          mon_active = 1'b0;
   bit          chk_gap = 1'b0;
   int unsigned gap = 0;
   int unsigned frames = 0;

   // line monitor: every bit must hold for exactly tb_div clocks
   initial begin
      int unsigned pos;
      int unsigned bi;
      logic [9:0]  bits;
      bit          stable;
      pos = 0;
      bits = '0;
      stable = 1'b1;
      forever begin
         @(negedge clk);
         if (rst) begin
            mon_active = 1'b0;
            gap = 0;
         end else if (!mon_active) begin
            if (txd === 1'b0) begin
               if (chk_gap && frames > 0) check("tx_gap", gap, 0);
               mon_active = 1'b1;
               bits = '0;
               stable = 1'b1;
               pos = 1;
            end else begin
               gap++;
            end
         end else begin
            bi = pos / tb_div;
            if (pos % tb_div == 0) bits[bi] = txd;
            else if (txd !== bits[bi]) stable = 1'b0;
            pos++;
            if (pos == 10 * tb_div) begin
               mon_active = 1'b0;
               gap = 0;
               frames++;
               check("tx_bit_len", stable, 1);
               check("tx_start", bits[0], 0);
               check("tx_stop", bits[9], 1);
               check("tx_queue_nonempty", tx_exp.size() != 0, 1);
               if (tx_exp.size() != 0) check("tx_byte", bits[8:1], tx_exp.pop_front());
            end
         end
      end
   end

   task automatic tick(input int unsigned n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
      addr = a;
      wdata = d;
      we = 1'b1;
      tick(1);
      we = 1'b0;
   endtask

   task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
      addr = a;
      re = 1'b1;
      #1;
      d = rdata;
      tick(1);
      re = 1'b0;
   endtask

   task automatic read_check(input logic [3:0] a, input logic [31:0] exp, input string tag);
      logic [31:0] d;
      bus_read(a, d);
      check(tag, d, exp);
   endtask

   task automatic wait_tx_done(input int unsigned budget);
      int unsigned c = 0;
      while ((tx_exp.size() != 0 || mon_active) && c < budget) begin
         tick(1);
         c++;
      end
      check("tx_done_in_time", c < budget, 1);
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stop);
      rxd = 1'b0;
      tick(tb_div);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         tick(tb_div);
      end
      rxd = stop;
      tick(tb_div);
      rxd = 1'b1;
      tick(tb_div);
   endtask

   initial begin
      logic [31:0] d;
      logic [7:0]  b;

      tick(3);
      rst = 1'b0;
      check("reset_txd", txd, 1);
      check("reset_irq", irq, 0);
      read_check(4'h4, 32'h01, "reset_status");
      read_check(4'h8, 32'd434, "reset_divisor");
      bus_write(4'hC, 32'hFFFF_FFFF);
      read_check(4'hC, 32'h0, "reserved_read");

      // single frame at 4 clocks per bit
      tb_div = 4;
      bus_write(4'h8, 32'd4);
      read_check(4'h8, 32'd4, "divisor_readback");
      tx_exp.push_back(8'h55);
      bus_write(4'h0, 32'h55);
      wait_tx_done(200);
      read_check(4'h4, 32'h01, "status_after_tx");

      // upper bits ignored; divisor 1 behaves as 2
      bus_write(4'h8, 32'hFFFF_0001);
      read_check(4'h8, 32'h1, "divisor_upper_bits");
      tb_div = 2;
      tx_exp.push_back(8'h3C);
      bus_write(4'h0, 32'h3C);
      wait_tx_done(200);

      // burst: first byte leaves the FIFO for the shifter, 16 more fill it, the 18th is dropped
      tb_div = 4;
      bus_write(4'h8, 32'd4);
      chk_gap = 1'b1;
      frames = 0;
      for (int i = 0; i < 18; i++) begin
         b = 8'(i * 13 + 5);
         if (i < 17) tx_exp.push_back(b);
         addr = 4'h0;
         wdata = {24'b0, b};
         we = 1'b1;
         tick(1);
      end
      we = 1'b0;
      read_check(4'h4, 32'h14, "burst_status_drop");
      read_check(4'h4, 32'h04, "burst_drop_cleared");
      wait_tx_done(17 * 40 + 200);
      chk_gap = 1'b0;
      check("burst_frames", frames, 17);
      read_check(4'h4, 32'h01, "burst_idle_status");

      // RX single frame
      tb_div = 8;
      bus_write(4'h8, 32'd8);
      rx_exp.push_back(8'hA3);
      send_rx(8'hA3, 1'b1);
      read_check(4'h4, 32'h03, "rx_status_valid");
      check("rx_irq_set", irq, 1);
      bus_read(4'h0, d);
      check("rx_data", d, {24'b0, rx_exp.pop_front()});
      check("rx_irq_clear", irq, 0);
      read_check(4'h4, 32'h01, "rx_status_clear");

      // overrun, then a framing error that must not disturb the held byte
      rx_exp.push_back(8'h11);
      send_rx(8'h11, 1'b1);
      rx_exp.push_back(8'hE7);
      send_rx(8'hE7, 1'b1);
      read_check(4'h4, 32'h0B, "rx_overrun_status");
      check("rx_overrun_irq", irq, 1);
      read_check(4'h4, 32'h03, "rx_overrun_cleared");
      send_rx(8'h5A, 1'b0);
      read_check(4'h4, 32'h03, "framing_keeps_valid");
      void'(rx_exp.pop_front());
      bus_read(4'h0, d);
      check("rx_overrun_data", d, {24'b0, rx_exp.pop_front()});

      // short glitch must not start a frame; receiver still works afterwards
      rxd = 1'b0;
      tick(2);
      rxd = 1'b1;
      tick(100);
      read_check(4'h4, 32'h01, "glitch_no_frame");
      check("glitch_irq", irq, 0);
      rx_exp.push_back(8'h6C);
      send_rx(8'h6C, 1'b1);
      bus_read(4'h0, d);
      check("rx_after_glitch", d, {24'b0, rx_exp.pop_front()});

      // reset in the middle of a TX frame
      tb_div = 4;
      bus_write(4'h8, 32'd4);
      bus_write(4'h0, 32'hC3);
      tick(15);
      check("midframe_txd_low", txd, 0);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check("reset_mid_txd", txd, 1);
      read_check(4'h4, 32'h01, "reset_mid_status");
      read_check(4'h8, 32'd434, "reset_mid_divisor");
      bus_write(4'h8, 32'd4);
      tx_exp.push_back(8'h96);
      bus_write(4'h0, 32'h96);
      wait_tx_done(200);
      read_check(4'h4, 32'h01, "post_reset_status");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
